// File: rtl/median_pkg.sv
// Shared types and constants for the median IP column reader.
//   PIX_W        default pixel width
//   pixel_t      one pixel at the default width
//   col_t        vertical 3-pixel column {top, mid, bot}
//   LINES_STEADY lines-counter value once two full rows are buffered
package median_pkg;

    localparam int unsigned PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t top;
        pixel_t mid;
        pixel_t bot;
    } col_t;

    localparam logic [1:0] LINES_STEADY = 2'd2;

endpackage

// File: rtl/median_line_store.sv
// One line of pixel storage. The read is combinational from the current address and the
// write lands on the clock edge, so a same-cycle read at the write address returns the
// old contents. Contents are never reset.
// Ports:
//   clk_i     clock
//   we_i      write enable
//   addr_i    shared read/write address
//   wdata_i   data written at addr_i
//   rdata_o   old contents at addr_i
module median_line_store #(
    parameter int unsigned N     = 8,
    parameter int unsigned Depth = 64,
    parameter int unsigned AW    = $clog2(Depth)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [N-1:0]  wdata_i,
    output logic [N-1:0]  rdata_o
);

    logic [N-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/median_column_reader.sv
// Read side of the median pixel delay path. For every accepted raster pixel it emits the
// aligned vertical column (y-2, y-1, y) at that x, one clock later. Two chained line
// stores (L1 -> L2) hold the previous two rows. Rows that do not exist yet at the top of a
// frame are zeroed, or replicated when BORDER_REPLICATE_EN is defined.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid_i    pixel present; in_sof_i marks x=0,y=0 of a new frame
//   in_data_i     pixel value
//   col_valid_o   column outputs valid
//   col_top_o / col_mid_o / col_bot_o   pixels at (x,y-2) / (x,y-1) / (x,y)
//   col_first_o / col_last_o            column is x=0 / x=H_ACTIVE-1
module median_column_reader
    import median_pkg::*;
#(
    parameter int unsigned N        = PIX_W,
    parameter int unsigned H_ACTIVE = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    input  logic         in_sof_i,
    input  logic [N-1:0] in_data_i,
    output logic         col_valid_o,
    output logic [N-1:0] col_top_o,
    output logic [N-1:0] col_mid_o,
    output logic [N-1:0] col_bot_o,
    output logic         col_first_o,
    output logic         col_last_o
);

    localparam int unsigned    XW     = $clog2(H_ACTIVE);
    localparam logic [XW-1:0]  X_LAST = XW'(H_ACTIVE - 1);

    logic [XW-1:0] x_q, x_d, x_cur;
    logic [1:0]    lines_q, lines_d, lines_cur;
    logic [N-1:0]  rd1, rd2;
    logic [N-1:0]  top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic          valid_q, valid_d, first_q, first_d, last_q, last_d;

    // sof restarts the frame on this very pixel, so it overrides the counters combinationally.
    assign x_cur     = in_sof_i ? '0 : x_q;
    assign lines_cur = in_sof_i ? '0 : lines_q;

    median_line_store #(
        .N     (N),
        .Depth (H_ACTIVE),
        .AW    (XW)
    ) u_line1 (
        .clk_i   (clk),
        .we_i    (in_valid_i),
        .addr_i  (x_cur),
        .wdata_i (in_data_i),
        .rdata_o (rd1)
    );

    median_line_store #(
        .N     (N),
        .Depth (H_ACTIVE),
        .AW    (XW)
    ) u_line2 (
        .clk_i   (clk),
        .we_i    (in_valid_i),
        .addr_i  (x_cur),
        .wdata_i (rd1),
        .rdata_o (rd2)
    );

    always_comb begin
        x_d     = x_q;
        lines_d = lines_q;
        valid_d = in_valid_i;
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        first_d = first_q;
        last_d  = last_q;
        if (in_valid_i) begin
            if (x_cur == X_LAST) begin
                x_d     = '0;
                lines_d = (lines_cur == LINES_STEADY) ? lines_cur : lines_cur + 2'd1;
            end else begin
                x_d     = x_cur + 1'b1;
                lines_d = lines_cur;
            end
            bot_d   = in_data_i;
            mid_d   = rd1;
            top_d   = rd2;
`ifdef BORDER_REPLICATE_EN
            if (lines_cur == 2'd0) begin
                top_d = in_data_i;
                mid_d = in_data_i;
            end else if (lines_cur == 2'd1) begin
                top_d = rd1;
            end
`else
            // Stale store contents from before this frame must never leak out.
            if (lines_cur == 2'd0) begin
                top_d = '0;
                mid_d = '0;
            end else if (lines_cur == 2'd1) begin
                top_d = '0;
            end
`endif
            first_d = (x_cur == '0);
            last_d  = (x_cur == X_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            lines_q <= '0;
            valid_q <= 1'b0;
            top_q   <= '0;
            mid_q   <= '0;
            bot_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            lines_q <= lines_d;
            valid_q <= valid_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            bot_q   <= bot_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign col_valid_o = valid_q;
    assign col_top_o   = top_q;
    assign col_mid_o   = mid_q;
    assign col_bot_o   = bot_q;
    assign col_first_o = first_q;
    assign col_last_o  = last_q;

endmodule

// File: tb/tb_median_column_reader.sv
// Bench for median_column_reader: two instances (H_ACTIVE=4 and 64) share one input stream.
// A frame-level model (pixel image indexed by row/column) predicts every column.
module tb_median_column_reader;
    import median_pkg::*;

    int unsigned wid [2] = '{4, 64};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid, in_sof;
    logic [7:0] in_data;

    logic       c_valid [2];
    logic       c_first [2];
    logic       c_last  [2];
    logic [7:0] c_top   [2];
    logic [7:0] c_mid   [2];
    logic [7:0] c_bot   [2];

    always #5 clk = ~clk;

    median_column_reader #(.N(8), .H_ACTIVE(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_sof_i    (in_sof),
        .in_data_i   (in_data),
        .col_valid_o (c_valid[0]),
        .col_top_o   (c_top[0]),
        .col_mid_o   (c_mid[0]),
        .col_bot_o   (c_bot[0]),
        .col_first_o (c_first[0]),
        .col_last_o  (c_last[0])
    );

    median_column_reader #(.N(8), .H_ACTIVE(64)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_sof_i    (in_sof),
        .in_data_i   (in_data),
        .col_valid_o (c_valid[1]),
        .col_top_o   (c_top[1]),
        .col_mid_o   (c_mid[1]),
        .col_bot_o   (c_bot[1]),
        .col_first_o (c_first[1]),
        .col_last_o  (c_last[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: current position within the frame and the last three rows of the image.
    typedef struct {
        logic valid;
        logic first;
        logic last;
        col_t col;
    } exp_t;

    int         mx [2];
    int         my [2];
    logic [7:0] img [2][3][64];
    exp_t       ex [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = 0;
            my[k] = 0;
            ex[k].valid = 1'b0;
            ex[k].first = 1'b0;
            ex[k].last  = 1'b0;
            ex[k].col   = '0;
        end
    endtask

    task automatic model_pix(input int k, input logic s, input logic [7:0] d);
        logic [7:0] up1, up2;
        if (s) begin
            mx[k] = 0;
            my[k] = 0;
        end
        up1 = (my[k] >= 1) ? img[k][(my[k] - 1) % 3][mx[k]] : 8'h00;
        up2 = (my[k] >= 2) ? img[k][(my[k] - 2) % 3][mx[k]] : 8'h00;
        ex[k].valid   = 1'b1;
        ex[k].col.bot = d;
`ifdef BORDER_REPLICATE_EN
        if (my[k] == 0) begin
            ex[k].col.mid = d;
            ex[k].col.top = d;
        end else if (my[k] == 1) begin
            ex[k].col.mid = up1;
            ex[k].col.top = up1;
        end else begin
            ex[k].col.mid = up1;
            ex[k].col.top = up2;
        end
`else
        ex[k].col.mid = up1;
        ex[k].col.top = up2;
`endif
        ex[k].first = (mx[k] == 0);
        ex[k].last  = (mx[k] == int'(wid[k]) - 1);
        img[k][my[k] % 3][mx[k]] = d;
        mx[k]++;
        if (mx[k] == int'(wid[k])) begin
            mx[k] = 0;
            my[k]++;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("valid_w%0d", wid[k]), 32'(c_valid[k]), 32'(ex[k].valid));
            check_eq($sformatf("first_w%0d", wid[k]), 32'(c_first[k]), 32'(ex[k].first));
            check_eq($sformatf("last_w%0d", wid[k]), 32'(c_last[k]), 32'(ex[k].last));
            check_eq($sformatf("top_w%0d", wid[k]), 32'(c_top[k]), 32'(ex[k].col.top));
            check_eq($sformatf("mid_w%0d", wid[k]), 32'(c_mid[k]), 32'(ex[k].col.mid));
            check_eq($sformatf("bot_w%0d", wid[k]), 32'(c_bot[k]), 32'(ex[k].col.bot));
        end
    endtask

    // Check the previous cycle's columns, then present the next input.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        check_outputs();
        for (int k = 0; k < 2; k++) begin
            if (v) model_pix(k, s, d);
            else   ex[k].valid = 1'b0;
        end
        in_valid = v;
        in_sof   = s;
        in_data  = d;
    endtask

    // Hand-computed column of the H_ACTIVE=4 instance, sampled 1 clk after the last step.
    task automatic peek4(input string tag, input logic f, input logic l,
                         input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
        @(posedge clk);
        #1;
        check_eq({tag, ".valid"}, 32'(c_valid[0]), 32'd1);
        check_eq({tag, ".first"}, 32'(c_first[0]), 32'(f));
        check_eq({tag, ".last"},  32'(c_last[0]),  32'(l));
        check_eq({tag, ".top"},   32'(c_top[0]),   32'(t));
        check_eq({tag, ".mid"},   32'(c_mid[0]),   32'(m));
        check_eq({tag, ".bot"},   32'(c_bot[0]),   32'(b));
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_eq({tag, ".valid"}, 32'(c_valid[k]), 32'd0);
            check_eq({tag, ".flags"}, 32'({c_first[k], c_last[k]}), 32'd0);
            check_eq({tag, ".data"},  32'({c_top[k], c_mid[k], c_bot[k]}), 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned nlines, trunc, npix;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
        model_reset();

        #1 rst_n = 1'b0;
        #3 check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp frame, pixel = 10*y + x.
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                step(1'b1, (y == 0) && (x == 0), 8'(10 * y + x));
`ifdef BORDER_REPLICATE_EN
                if (y == 0 && x == 2) peek4("y0x2", 1'b0, 1'b0, 8'd2, 8'd2, 8'd2);
                if (y == 1 && x == 2) peek4("y1x2", 1'b0, 1'b0, 8'd2, 8'd2, 8'd12);
`else
                if (y == 0 && x == 2) peek4("y0x2", 1'b0, 1'b0, 8'd0, 8'd0, 8'd2);
                if (y == 1 && x == 2) peek4("y1x2", 1'b0, 1'b0, 8'd0, 8'd2, 8'd12);
`endif
                if (y == 2 && x == 1) peek4("y2x1", 1'b0, 1'b0, 8'd1, 8'd11, 8'd21);
                if (y == 2 && x == 3) peek4("y2x3", 1'b0, 1'b1, 8'd3, 8'd13, 8'd23);
            end
        end

        // Mid-line sof at x=2 of line 3.
        step(1'b1, 1'b0, 8'd30);
        step(1'b1, 1'b0, 8'd31);
        step(1'b1, 1'b1, 8'd99);
`ifdef BORDER_REPLICATE_EN
        peek4("sof_mid", 1'b1, 1'b0, 8'd99, 8'd99, 8'd99);
        step(1'b1, 1'b0, 8'd77);
        peek4("sof_next", 1'b0, 1'b0, 8'd77, 8'd77, 8'd77);
`else
        peek4("sof_mid", 1'b1, 1'b0, 8'd0, 8'd0, 8'd99);
        step(1'b1, 1'b0, 8'd77);
        peek4("sof_next", 1'b0, 1'b0, 8'd0, 8'd0, 8'd77);
`endif

        // Gaps and a bare sof (ignored).
        step(1'b1, 1'b0, 8'd5);
        step(1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd6);
        step(1'b0, 1'b1, 8'd0);
        step(1'b1, 1'b0, 8'd7);
        step(1'b1, 1'b0, 8'd8);

        // Asynchronous reset mid-line.
        @(negedge clk);
        check_outputs();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'd42);
`ifdef BORDER_REPLICATE_EN
        peek4("post_rst", 1'b1, 1'b0, 8'd42, 8'd42, 8'd42);
`else
        peek4("post_rst", 1'b1, 1'b0, 8'd0, 8'd0, 8'd42);
`endif

        // Ten random frames; every third one is cut short by the next sof.
        for (int f = 0; f < 10; f++) begin
            nlines = $urandom_range(8, 3);
            trunc  = (f % 3 == 2) ? $urandom_range(40, 1) : 0;
            npix   = 64 * nlines - trunc;
            for (int p = 0; p < int'(npix); p++) begin
                if ($urandom_range(7, 0) == 0) begin
                    step(1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
                end
                step(1'b1, p == 0, 8'($urandom));
            end
        end

        step(1'b0, 1'b0, 8'd0);
        @(negedge clk);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
